// File: rtl/register_file.sv
// Architectural integer register file with a pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass; a busy bit
// per entry is set at issue and cleared at writeback, and a used source that
// is still in flight raises Stall to decode.
//
// Port protocol: the writeback port has no handshake; every cycle with
// Wr_En=1 is accepted at the next posedge. The issue port is accepted on a
// posedge only when Issue_En=1 and Stall=0 in that cycle; decode must hold
// its instruction while Stall=1.
module register_file #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] WrtBck_Addr,
  input  logic                      Wr_En,
  input  logic [DATA_WIDTH-1:0]     Wr_Data,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_Addr,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_Addr,
  input  logic                      Rs1_Used,
  input  logic                      Rs2_Used,
  input  logic                      Issue_En,
  input  logic [REG_ADDR_WIDTH-1:0] Issue_Rd,
  output logic [DATA_WIDTH-1:0]     Rs1_Data,
  output logic [DATA_WIDTH-1:0]     Rs2_Data,
  output logic                      Stall,
  output logic [REG_ADDR_WIDTH:0]   Pending_Cnt
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int CNT_W    = REG_ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  logic wr_fire;
  logic set_fire;
  logic byp1;
  logic byp2;
  logic cnt_inc;
  logic cnt_dec;

  // Qualified write and issue events; x0 never takes part in either.
  always_comb begin
    wr_fire  = Wr_En && (WrtBck_Addr != '0);
    set_fire = Issue_En && (Issue_Rd != '0) && !Stall;
    byp1     = Wr_En && (WrtBck_Addr == Rs1_Addr);
    byp2     = Wr_En && (WrtBck_Addr == Rs2_Addr);
  end

  // Read ports: x0 reads zero, then bypass from writeback, then storage.
  always_comb begin
    Rs1_Data = regs_q[Rs1_Addr];
    Rs2_Data = regs_q[Rs2_Addr];
    if (byp1) Rs1_Data = Wr_Data;
    if (byp2) Rs2_Data = Wr_Data;
    if (Rs1_Addr == '0) Rs1_Data = '0;
    if (Rs2_Addr == '0) Rs2_Data = '0;
  end

  // Hazard detect: a retiring write to the same index is resolved by bypass.
  always_comb begin
    Stall = (Rs1_Used && busy_q[Rs1_Addr] && !byp1) ||
            (Rs2_Used && busy_q[Rs2_Addr] && !byp2);
  end

  // Next scoreboard state: clear first, then set, so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire)  busy_d[WrtBck_Addr] = 1'b0;
    if (set_fire) busy_d[Issue_Rd]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Counter tracks popcount: count only real 0->1 and 1->0 transitions.
  always_comb begin
    cnt_inc = set_fire && !busy_q[Issue_Rd];
    cnt_dec = wr_fire && busy_q[WrtBck_Addr] &&
              !(set_fire && (Issue_Rd == WrtBck_Addr));
    cnt_d   = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Register storage; entry 0 stays zero because writes to it are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[WrtBck_Addr] <= Wr_Data;
    end
  end

  // Scoreboard bits and pending counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Pending_Cnt = cnt_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, hand-written corner
// sequences (async reset, fill/drain) and randomized traffic against an
// array-based reference model.
module tb_register_file;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] WrtBck_Addr;
  logic          Wr_En;
  logic [DW-1:0] Wr_Data;
  logic [AW-1:0] Rs1_Addr;
  logic [AW-1:0] Rs2_Addr;
  logic          Rs1_Used;
  logic          Rs2_Used;
  logic          Issue_En;
  logic [AW-1:0] Issue_Rd;
  logic [DW-1:0] Rs1_Data;
  logic [DW-1:0] Rs2_Data;
  logic          Stall;
  logic [AW:0]   Pending_Cnt;

  register_file #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .WrtBck_Addr(WrtBck_Addr), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr),
    .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
    .Issue_En(Issue_En), .Issue_Rd(Issue_Rd),
    .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Stall(Stall), .Pending_Cnt(Pending_Cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state as plain arrays
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (Wr_En && WrtBck_Addr == a) return Wr_Data;
    return m_regs[a];
  endfunction

  function automatic bit m_src_wait(input logic used, input logic [AW-1:0] a);
    return used && m_busy[a] && !(Wr_En && WrtBck_Addr == a);
  endfunction

  function automatic bit m_stall();
    return m_src_wait(Rs1_Used, Rs1_Addr) || m_src_wait(Rs2_Used, Rs2_Addr);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic u1, input logic u2,
                       input logic ie, input logic [AW-1:0] rd);
    Wr_En = we; WrtBck_Addr = wa; Wr_Data = wd;
    Rs1_Addr = r1; Rs2_Addr = r2; Rs1_Used = u1; Rs2_Used = u2;
    Issue_En = ie; Issue_Rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Advance one edge; the model applies the same cycle's events by rule.
  task automatic step();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (Wr_En && WrtBck_Addr != 0) begin
      m_regs[WrtBck_Addr] = Wr_Data;
      m_busy[WrtBck_Addr] = 1'b0;
    end
    if (Issue_En && Issue_Rd != 0 && !st) m_busy[Issue_Rd] = 1'b1;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rs1"},   Rs1_Data, m_read(Rs1_Addr));
    chk({tag, ".rs2"},   Rs2_Data, m_read(Rs2_Addr));
    chk({tag, ".stall"}, {31'd0, Stall}, {31'd0, m_stall()});
    chk({tag, ".cnt"},   {26'd0, Pending_Cnt}, m_count());
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1, r2;
    logic          u1, u2, ie;
    logic [AW-1:0] rd;
    logic [DW-1:0] e1, e2;
    logic          es;
    logic [AW:0]   ec;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                              input logic u1, input logic u2, input logic ie, input logic [AW-1:0] rd,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input logic es, input logic [AW:0] ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.u1 = u1; v.u2 = u2; v.ie = ie; v.rd = rd;
    v.e1 = e1; v.e2 = e2; v.es = es; v.ec = ec;
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    model_reset();

    // Expected values below are the outputs before the row's edge.
    //           we wa  wd            r1 r2 u1 u2 ie rd  e1            e2            es ec
    tbl[0]  = mk(1, 3, 32'h12345678, 3, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        0, 0);
    tbl[1]  = mk(1, 0, 32'hFFFFFFFF, 3, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 3, 0, 0, 0, 0, 32'h0,        32'h12345678, 0, 0);
    tbl[3]  = mk(1, 7, 32'hA5A5A5A5, 3, 7, 0, 0, 0, 0, 32'h12345678, 32'hA5A5A5A5, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        7, 0, 1, 0, 1, 9, 32'hA5A5A5A5, 32'h0,        0, 0);
    tbl[5]  = mk(0, 0, 32'h0,        9, 0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 1);
    tbl[6]  = mk(0, 0, 32'h0,        9, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    tbl[7]  = mk(0, 0, 32'h0,        0, 9, 0, 1, 0, 0, 32'h0,        32'h0,        1, 1);
    tbl[8]  = mk(1, 9, 32'hCAFEF00D, 9, 0, 1, 0, 0, 0, 32'hCAFEF00D, 32'h0,        0, 1);
    tbl[9]  = mk(0, 0, 32'h0,        9, 0, 1, 0, 0, 0, 32'hCAFEF00D, 32'h0,        0, 0);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 4, 32'h0,        32'h0,        0, 0);
    tbl[11] = mk(1, 4, 32'h11112222, 4, 0, 0, 0, 1, 4, 32'h11112222, 32'h0,        0, 1);
    tbl[12] = mk(0, 0, 32'h0,        4, 0, 1, 0, 1, 5, 32'h11112222, 32'h0,        1, 1);
    tbl[13] = mk(1, 4, 32'h33334444, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    tbl[14] = mk(0, 0, 32'h0,        4, 5, 0, 1, 0, 0, 32'h33334444, 32'h0,        0, 0);

    #12;
    chk("reset.cnt",   {26'd0, Pending_Cnt}, 32'd0);
    chk("reset.stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2,
            tbl[i].u1, tbl[i].u2, tbl[i].ie, tbl[i].rd);
      #1;
      chk($sformatf("vec%0d.rs1", i),   Rs1_Data, tbl[i].e1);
      chk($sformatf("vec%0d.rs2", i),   Rs2_Data, tbl[i].e2);
      chk($sformatf("vec%0d.stall", i), {31'd0, Stall}, {31'd0, tbl[i].es});
      chk($sformatf("vec%0d.cnt", i),   {26'd0, Pending_Cnt}, {26'd0, tbl[i].ec});
      step();
    end

    // Asynchronous reset mid-cycle discards storage and scoreboard
    drive(1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 1'b1, 6);
    step();
    drive(1'b0, 0, 0, 5, 6, 1'b0, 1'b1, 1'b0, 0);
    #1;
    chk("prerst.rs1", Rs1_Data, 32'hDEADBEEF);
    chk("prerst.stall", {31'd0, Stall}, 32'd1);
    chk("prerst.cnt", {26'd0, Pending_Cnt}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst.rs1", Rs1_Data, 32'h0);
    chk("midrst.stall", {31'd0, Stall}, 32'd0);
    chk("midrst.cnt", {26'd0, Pending_Cnt}, 32'd0);
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill every destination, then re-issue a busy one; no wrap
    for (int r = 1; r < NR; r++) begin
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, AW'(r));
      step();
    end
    idle();
    #1;
    chk("fill.cnt", {26'd0, Pending_Cnt}, 32'd31);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 31);
    step();
    chk("fill_again.cnt", {26'd0, Pending_Cnt}, 32'd31);

    // Drain all, then a write to an idle register must not underflow
    for (int r = 1; r < NR; r++) begin
      drive(1'b1, AW'(r), $urandom, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      step();
    end
    idle();
    #1;
    chk("drain.cnt", {26'd0, Pending_Cnt}, 32'd0);
    drive(1'b1, 12, 32'h0BADF00D, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    step();
    drive(1'b0, 0, 0, 12, 0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("idle_wr.cnt", {26'd0, Pending_Cnt}, 32'd0);
    chk("idle_wr.rs1", Rs1_Data, 32'h0BADF00D);

    // Randomized traffic on a narrow address window for frequent hazards
    for (int c = 0; c < 600; c++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, hi)), $urandom,
            AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, hi)));
      #1;
      chk_model($sformatf("rnd%0d", c));
      step();
    end
    idle();
    #1;
    chk_model("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file with a pending-write scoreboard; the responder end of the writeback write port. It accepts the address, enable and data driven by the writeback stage, stores results, and serves two combinational read ports to decode with same-cycle write-to-read bypass. A busy-bit scoreboard, set at issue and cleared at writeback, raises a stall to decode when a source operand is still in flight.

## Interface
Parameters:
- `REG_ADDR_WIDTH`: default 5. Register index width; 2**REG_ADDR_WIDTH entries.
- `DATA_WIDTH`: default 32. Register data width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `WrtBck_Addr`  in  REG_ADDR_WIDTH  destination register from writeback.
- `Wr_En`  in  1  write strobe from writeback.
- `Wr_Data`  in  DATA_WIDTH  result to write.
- `Rs1_Addr`, `Rs2_Addr`  in  REG_ADDR_WIDTH  decode source indices.
- `Rs1_Used`, `Rs2_Used`  in  1  source is actually consumed by the decoding instruction.
- `Issue_En`  in  1  decode issues an instruction with a destination this cycle.
- `Issue_Rd`  in  REG_ADDR_WIDTH  destination of the issuing instruction.
- `Rs1_Data`, `Rs2_Data`  out  DATA_WIDTH  read data, combinational.
- `Stall`  out  1  a used source is pending; decode must hold.
- `Pending_Cnt`  out  REG_ADDR_WIDTH+1  number of busy registers.

## Operation
- Storage: 2**REG_ADDR_WIDTH x DATA_WIDTH flops. Entry 0 is hardwired zero: writes to 0 are dropped, and reads of 0 return 0.
- Write: on posedge, if `Wr_En` and `WrtBck_Addr`!=0, then `regs[WrtBck_Addr]<=Wr_Data`.
- Read: `RsN_Data` = 0 if `RsN_Addr`==0; else `Wr_Data` if `Wr_En` and `WrtBck_Addr`==`RsN_Addr` (bypass); else `regs[RsN_Addr]`.
- Scoreboard: one busy bit per entry; bit 0 is constant 0.
  - Set on posedge when `Issue_En` and `Issue_Rd`!=0 and `Stall`==0.
  - Clear on posedge when `Wr_En` and `WrtBck_Addr`!=0.
  - If set and clear target the same index in the same cycle, set wins; a new producer supersedes the retiring one.
  - Set on an already-busy entry leaves it busy and does not change the count.
- Stall: `Stall` = OR over N of (`RsN_Used` and `busy[RsN_Addr]` and not (`Wr_En` and `WrtBck_Addr`==`RsN_Addr`)). A write retiring in the same cycle resolves the hazard through the bypass. `Issue_Rd` does not affect `Stall`; WAW is covered because set wins.
- `Pending_Cnt`: popcount of busy bits, held as a registered counter updated by +1, -1, 0 or net 0 for set and clear in the same cycle. It never wraps; its maximum is 2**REG_ADDR_WIDTH-1.
- A write to a register that is not busy is legal, updates storage and leaves the count unchanged.

## Timing
- Reset (`reset`=0, asynchronous): all registers 0, all busy bits 0, `Pending_Cnt`=0. `Stall`=0 and `RsN_Data`=0 follow combinationally. Reset asserted mid-operation discards pending writes and scoreboard state immediately. Deassertion is synchronous to `clk` at the system level.
- Read latency is 0 cycles (combinational). Write latency is 1 cycle into storage, with 0-cycle visibility through the bypass.
- A busy bit set at edge T is observable as `Stall` from T onward. The writeback that clears it at edge T+k releases `Stall` in the cycle before that edge, through the bypass term.
- No handshake on the write port: every cycle with `Wr_En`=1 is accepted. Issue is accepted only when `Stall`==0.

## Test plan
- Reset: load 0xDEADBEEF into x5, assert `reset`=0 mid-cycle -> `Rs1_Data`=0 for x5 immediately, `Pending_Cnt`=0, `Stall`=0.
- Write/read and x0: write 0x12345678 to x3, then 0xFFFFFFFF to x0 -> the next cycle reads x3=0x12345678 and x0=0.
- Bypass: `Wr_En`=1, `WrtBck_Addr`=7, `Wr_Data`=0xA5A5A5A5 with `Rs2_Addr`=7 in the same cycle -> `Rs2_Data`=0xA5A5A5A5 before the edge.
- RAW stall: issue with `Issue_Rd`=9, then decode with `Rs1_Addr`=9 and `Rs1_Used`=1 -> `Stall`=1 and `Pending_Cnt`=1.
  - Writeback to x9 -> `Stall`=0 in that same cycle, `Rs1_Data`=write data, count 0 after the edge.
  - With `Rs1_Used`=0 -> no stall.
- Simultaneous set and clear: x4 busy; in one cycle issue `Issue_Rd`=4 and write back x4 -> x4 remains busy, `Pending_Cnt` unchanged at 1.
- Fill: issue destinations 1..31 with no writebacks -> `Pending_Cnt`=31. Retire all 31 -> `Pending_Cnt`=0, with no wrap at either end.
